// File: rtl/axil_cmd_pkg.sv
// Shared opcodes, status bytes and FSM state type for the byte-stream AXI-Lite command master.
// The optional inter-byte timeout is enabled by defining AXIL_CMD_TIMEOUT_EN.
package axil_cmd_pkg;

    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] ST_BADOP   = 8'hEE;
    localparam logic [7:0] ST_TIMEOUT = 8'hFD;

    // Wide enough to count up to five response bytes or four field bytes.
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WR,
        WR_B,
        RD_AR,
        RD_R,
        RESP
    } state_e;

    function automatic logic [7:0] statusByte(input logic [1:0] resp);
        return {6'b0, resp};
    endfunction

endpackage

// File: rtl/axil_cmd_rsp_ser.sv
// Loadable response serializer: holds up to NBYTES bytes (first byte in the top lane) and
// streams them out one per accepted beat, flagging the final byte with tlast.
module axil_cmd_rsp_ser
    import axil_cmd_pkg::*;
#(
    parameter int NBYTES = 5
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  load_i,
    input  logic [NBYTES*8-1:0]   data_i,
    input  logic [CNT_W-1:0]      count_i,
    output logic [7:0]            m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  m_axis_tlast_o,
    output logic                  busy_o,
    output logic                  done_o
);

    logic [NBYTES*8-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                beat;

    assign m_axis_tvalid_o = (cnt_q != '0);
    assign m_axis_tdata_o  = buf_q[NBYTES*8-1 -: 8];
    assign m_axis_tlast_o  = (cnt_q == CNT_W'(1));
    assign beat            = m_axis_tvalid_o && m_axis_tready_i;
    assign busy_o          = m_axis_tvalid_o;
    assign done_o          = beat && m_axis_tlast_o;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (load_i) begin
            buf_d = data_i;
            cnt_d = count_i;
        end else if (beat) begin
            buf_d = buf_q << 8;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axil_cmd_master.sv
// Byte-stream to AXI-Lite master: parses one framed read/write command, runs exactly one
// AXI-Lite transaction and returns a status/data frame. Inter-byte timeout: AXIL_CMD_TIMEOUT_EN.
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,

    input  logic [7:0]                   s_axis_tdata_i,
    input  logic                         s_axis_tvalid_i,
    output logic                         s_axis_tready_o,

    output logic [7:0]                   m_axis_tdata_o,
    output logic                         m_axis_tvalid_o,
    input  logic                         m_axis_tready_i,
    output logic                         m_axis_tlast_o,

    output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr_o,
    output logic [2:0]                   m_axil_awprot_o,
    output logic                         m_axil_awvalid_o,
    input  logic                         m_axil_awready_i,
    output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata_o,
    output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb_o,
    output logic                         m_axil_wvalid_o,
    input  logic                         m_axil_wready_i,
    input  logic [1:0]                   m_axil_bresp_i,
    input  logic                         m_axil_bvalid_i,
    output logic                         m_axil_bready_o,
    output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr_o,
    output logic [2:0]                   m_axil_arprot_o,
    output logic                         m_axil_arvalid_o,
    input  logic                         m_axil_arready_i,
    input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata_i,
    input  logic [1:0]                   m_axil_rresp_i,
    input  logic                         m_axil_rvalid_i,
    output logic                         m_axil_rready_o
);

    localparam int AB    = AXIL_ADDR_WIDTH / 8;
    localparam int DB    = AXIL_DATA_WIDTH / 8;
    localparam int RSP_N = DB + 1;
    localparam int RSP_W = RSP_N * 8;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             byteCnt_q, byteCnt_d;
    logic [AXIL_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [AXIL_DATA_WIDTH-1:0]   data_q, data_d;
    logic                         isWrite_q, isWrite_d;
    logic                         awDone_q, awDone_d;
    logic                         wDone_q, wDone_d;
    logic                         active_q;

    logic                         serLoad;
    logic [RSP_W-1:0]             serData;
    logic [CNT_W-1:0]             serCount;
    logic                         serBusy;
    logic                         serDone;
    logic                         accept;
    logic                         awHs;
    logic                         wHs;

`ifdef AXIL_CMD_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

    assign m_axil_awaddr_o = addr_q;
    assign m_axil_araddr_o = addr_q;
    assign m_axil_wdata_o  = data_q;
    assign m_axil_wstrb_o  = '1;
    assign m_axil_awprot_o = 3'b000;
    assign m_axil_arprot_o = 3'b000;

    // active_q keeps tready low while reset is held even though the state reads IDLE.
    always_comb begin
        state_d          = state_q;
        byteCnt_d        = byteCnt_q;
        addr_d           = addr_q;
        data_d           = data_q;
        isWrite_d        = isWrite_q;
        awDone_d         = awDone_q;
        wDone_d          = wDone_q;
        serLoad          = 1'b0;
        serData          = '0;
        serCount         = '0;
        m_axil_awvalid_o = 1'b0;
        m_axil_wvalid_o  = 1'b0;
        m_axil_bready_o  = 1'b0;
        m_axil_arvalid_o = 1'b0;
        m_axil_rready_o  = 1'b0;
        awHs             = 1'b0;
        wHs              = 1'b0;
        s_axis_tready_o  = active_q && !serBusy &&
                           (state_q == IDLE || state_q == ADDR || state_q == DATA);
        accept           = s_axis_tvalid_i && s_axis_tready_o;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (s_axis_tdata_i == OP_WRITE || s_axis_tdata_i == OP_READ) begin
                        isWrite_d = (s_axis_tdata_i == OP_WRITE);
                        byteCnt_d = '0;
                        state_d   = ADDR;
                    end else begin
                        serLoad  = 1'b1;
                        serData  = {ST_BADOP, {(RSP_W-8){1'b0}}};
                        serCount = CNT_W'(1);
                        state_d  = RESP;
                    end
                end
            end
            ADDR: begin
                if (accept) begin
                    addr_d = AXIL_ADDR_WIDTH'({addr_q, s_axis_tdata_i});
                    if (byteCnt_q == CNT_W'(AB-1)) begin
                        byteCnt_d = '0;
                        state_d   = isWrite_q ? DATA : RD_AR;
                    end else begin
                        byteCnt_d = byteCnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    data_d = AXIL_DATA_WIDTH'({data_q, s_axis_tdata_i});
                    if (byteCnt_q == CNT_W'(DB-1)) begin
                        byteCnt_d = '0;
                        state_d   = WR;
                    end else begin
                        byteCnt_d = byteCnt_q + CNT_W'(1);
                    end
                end
            end
            // AW and W are tracked separately so either channel may complete first.
            WR: begin
                m_axil_awvalid_o = !awDone_q;
                m_axil_wvalid_o  = !wDone_q;
                awHs             = awDone_q || m_axil_awready_i;
                wHs              = wDone_q || m_axil_wready_i;
                if (awHs && wHs) begin
                    awDone_d = 1'b0;
                    wDone_d  = 1'b0;
                    state_d  = WR_B;
                end else begin
                    awDone_d = awHs;
                    wDone_d  = wHs;
                end
            end
            WR_B: begin
                m_axil_bready_o = 1'b1;
                if (m_axil_bvalid_i) begin
                    serLoad  = 1'b1;
                    serData  = {statusByte(m_axil_bresp_i), {(RSP_W-8){1'b0}}};
                    serCount = CNT_W'(1);
                    state_d  = RESP;
                end
            end
            RD_AR: begin
                m_axil_arvalid_o = 1'b1;
                if (m_axil_arready_i) begin
                    state_d = RD_R;
                end
            end
            RD_R: begin
                m_axil_rready_o = 1'b1;
                if (m_axil_rvalid_i) begin
                    serLoad  = 1'b1;
                    serData  = {statusByte(m_axil_rresp_i), m_axil_rdata_i};
                    serCount = CNT_W'(RSP_N);
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (serDone) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef AXIL_CMD_TIMEOUT_EN
        // A stalled partial frame is dropped and answered with a single timeout byte.
        tmr_d = '0;
        if ((state_q == ADDR || state_q == DATA) && !accept) begin
            if (tmr_q == TMR_W'(TIMEOUT_CYCLES-1)) begin
                byteCnt_d = '0;
                serLoad   = 1'b1;
                serData   = {ST_TIMEOUT, {(RSP_W-8){1'b0}}};
                serCount  = CNT_W'(1);
                state_d   = RESP;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= IDLE;
            byteCnt_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            isWrite_q <= 1'b0;
            awDone_q  <= 1'b0;
            wDone_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            byteCnt_q <= byteCnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            isWrite_q <= isWrite_d;
            awDone_q  <= awDone_d;
            wDone_q   <= wDone_d;
            active_q  <= 1'b1;
        end
    end

`ifdef AXIL_CMD_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`endif

    axil_cmd_rsp_ser #(
        .NBYTES (RSP_N)
    ) u_rsp_ser (
        .clk_i           (clk_i),
        .arstn_i         (arstn_i),
        .load_i          (serLoad),
        .data_i          (serData),
        .count_i         (serCount),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i),
        .m_axis_tlast_o  (m_axis_tlast_o),
        .busy_o          (serBusy),
        .done_o          (serDone)
    );

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a small AXI-Lite slave model and response monitor.
// Timeout scenario runs only when AXIL_CMD_TIMEOUT_EN is defined.
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        arstn = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  sTdata = 8'h00;
    logic        sTvalid = 1'b0;
    logic        sTready;
    logic [7:0]  mTdata;
    logic        mTvalid, mTlast;
    logic        rspReady = 1'b1;

    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int          passCount = 0;
    int          checkCount = 0;

    int          awDelay = 0, wDelay = 0;
    logic [1:0]  bRespVal = 2'b00, rRespVal = 2'b00;
    logic [31:0] rDataVal = 32'h0;
    bit          arReadyEn = 1'b1;

    int          awHs = 0, wHs = 0, arHs = 0;
    int          awWait, wWait;
    logic        gotAw, gotW;
    logic [31:0] capAwaddr = '0, capWdata = '0, capAraddr = '0;
    logic [3:0]  capWstrb = '0;
    logic [7:0]  rspData[$];
    bit          rspLast[$];

    axil_cmd_master #(
        .AXIL_ADDR_WIDTH (32),
        .AXIL_DATA_WIDTH (32),
        .TIMEOUT_CYCLES  (100)
    ) dut (
        .clk_i            (clk),
        .arstn_i          (arstn),
        .s_axis_tdata_i   (sTdata),
        .s_axis_tvalid_i  (sTvalid),
        .s_axis_tready_o  (sTready),
        .m_axis_tdata_o   (mTdata),
        .m_axis_tvalid_o  (mTvalid),
        .m_axis_tready_i  (rspReady),
        .m_axis_tlast_o   (mTlast),
        .m_axil_awaddr_o  (awaddr),
        .m_axil_awprot_o  (awprot),
        .m_axil_awvalid_o (awvalid),
        .m_axil_awready_i (awready),
        .m_axil_wdata_o   (wdata),
        .m_axil_wstrb_o   (wstrb),
        .m_axil_wvalid_o  (wvalid),
        .m_axil_wready_i  (wready),
        .m_axil_bresp_i   (bresp),
        .m_axil_bvalid_i  (bvalid),
        .m_axil_bready_o  (bready),
        .m_axil_araddr_o  (araddr),
        .m_axil_arprot_o  (arprot),
        .m_axil_arvalid_o (arvalid),
        .m_axil_arready_i (arready),
        .m_axil_rdata_i   (rdata),
        .m_axil_rresp_i   (rresp),
        .m_axil_rvalid_i  (rvalid),
        .m_axil_rready_o  (rready)
    );

    // Slave model: AW/W ready after a programmable number of waiting cycles, B once both
    // have landed, R one cycle after the AR handshake.
    assign awready = awvalid && (awWait >= awDelay);
    assign wready  = wvalid && (wWait >= wDelay);
    assign arready = arvalid && arReadyEn;

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            awWait <= 0;
            wWait  <= 0;
            gotAw  <= 1'b0;
            gotW   <= 1'b0;
            bvalid <= 1'b0;
            bresp  <= 2'b00;
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= 2'b00;
        end else begin
            if (awvalid && awready) begin
                awHs      <= awHs + 1;
                capAwaddr <= awaddr;
                awWait    <= 0;
                gotAw     <= 1'b1;
            end else if (awvalid) begin
                awWait <= awWait + 1;
            end
            if (wvalid && wready) begin
                wHs      <= wHs + 1;
                capWdata <= wdata;
                capWstrb <= wstrb;
                wWait    <= 0;
                gotW     <= 1'b1;
            end else if (wvalid) begin
                wWait <= wWait + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
            end else if (!bvalid && (gotAw || (awvalid && awready)) && (gotW || (wvalid && wready))) begin
                bvalid <= 1'b1;
                bresp  <= bRespVal;
                gotAw  <= 1'b0;
                gotW   <= 1'b0;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0;
            end else if (arvalid && arready) begin
                rvalid    <= 1'b1;
                rdata     <= rDataVal;
                rresp     <= rRespVal;
                arHs      <= arHs + 1;
                capAraddr <= araddr;
            end
        end
    end

    // Response monitor records every accepted beat.
    always @(posedge clk) begin
        if (arstn && mTvalid && rspReady) begin
            rspData.push_back(mTdata);
            rspLast.push_back(mTlast);
        end
    end

    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        sTvalid = 1'b1;
        sTdata  = b;
        while (!sTready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sTready) begin
            checkCount++;
            $display("[TB] FAIL send_timeout byte=%h tready=%b required=1", b, sTready);
        end
        @(posedge clk);
        #1;
        sTvalid = 1'b0;
    endtask

    task automatic sendRead(input logic [31:0] addr);
        sendByte(8'h02);
        for (int i = 3; i >= 0; i--) sendByte(addr[8*i +: 8]);
    endtask

    task automatic sendWrite(input logic [31:0] addr, input logic [31:0] data);
        sendByte(8'h01);
        for (int i = 3; i >= 0; i--) sendByte(addr[8*i +: 8]);
        for (int i = 3; i >= 0; i--) sendByte(data[8*i +: 8]);
    endtask

    task automatic waitRsp(input int base, input int n);
        int c = 0;
        while (rspData.size() < base + n && c < 500) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
        if (rspData.size() < base + n) begin
            checkCount++;
            $display("[TB] FAIL rsp_timeout got=%0d bytes required=%0d", rspData.size() - base, n);
        end
    endtask

    task automatic test_reset();
        arstn = 1'b1;
        #2 arstn = 1'b0;
        #1;
        checkCount++;
        if ({awvalid, wvalid, arvalid, bready, rready, mTvalid, mTlast, sTready} !== 8'h00)
            $display("[TB] FAIL reset_outputs got=%b required=00000000",
                     {awvalid, wvalid, arvalid, bready, rready, mTvalid, mTlast, sTready});
        else passCount++;
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        checkCount++;
        if (sTready !== 1'b1) $display("[TB] FAIL idle_tready got=%b required=1", sTready);
        else passCount++;
    endtask

    task automatic test_write();
        int base = rspData.size();
        int awB = awHs, wB = wHs;
        sendWrite(32'h0000_0010, 32'hDEAD_BEEF);
        checkCount++;
        if ({awvalid, wvalid} !== 2'b11) $display("[TB] FAIL aw_w_latency got=%b required=11", {awvalid, wvalid});
        else passCount++;
        waitRsp(base, 1);
        checkCount++;
        if (capAwaddr !== 32'h10) $display("[TB] FAIL awaddr got=%h required=%h", capAwaddr, 32'h10);
        else passCount++;
        checkCount++;
        if (capWdata !== 32'hDEADBEEF) $display("[TB] FAIL wdata got=%h required=deadbeef", capWdata);
        else passCount++;
        checkCount++;
        if (capWstrb !== 4'hF) $display("[TB] FAIL wstrb got=%h required=f", capWstrb);
        else passCount++;
        checkCount++;
        if (rspData.size() !== base + 1) $display("[TB] FAIL wr_rsp_count got=%0d required=1", rspData.size() - base);
        else passCount++;
        if (rspData.size() > base) begin
            checkCount++;
            if (rspData[base] !== 8'h00 || rspLast[base] !== 1'b1)
                $display("[TB] FAIL wr_rsp got=%h/%b required=00/1", rspData[base], rspLast[base]);
            else passCount++;
        end
        checkCount++;
        if (awHs - awB !== 1 || wHs - wB !== 1)
            $display("[TB] FAIL wr_handshakes got=%0d/%0d required=1/1", awHs - awB, wHs - wB);
        else passCount++;
    endtask

    task automatic test_read_latency();
        int base = rspData.size();
        logic [7:0] expB[5] = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        int cyc = 1;
        rDataVal = 32'h1234_5678;
        rRespVal = 2'b00;
        sendRead(32'h0000_0020);
        // cyc counts cycles after the one in which the last byte was accepted.
        while (!mTvalid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkCount++;
        if (cyc !== 3) $display("[TB] FAIL rd_latency got=%0d required=3", cyc);
        else passCount++;
        waitRsp(base, 5);
        checkCount++;
        if (capAraddr !== 32'h20) $display("[TB] FAIL araddr got=%h required=20", capAraddr);
        else passCount++;
        checkCount++;
        if (rspData.size() !== base + 5) $display("[TB] FAIL rd_rsp_count got=%0d required=5", rspData.size() - base);
        else passCount++;
        for (int i = 0; i < 5 && base + i < rspData.size(); i++) begin
            checkCount++;
            if (rspData[base+i] !== expB[i] || rspLast[base+i] !== (i == 4))
                $display("[TB] FAIL rd_byte%0d got=%h/%b required=%h/%b", i, rspData[base+i],
                         rspLast[base+i], expB[i], (i == 4));
            else passCount++;
        end
    endtask

    task automatic test_skew_slverr();
        int base = rspData.size();
        int awB = awHs, wB = wHs;
        awDelay  = 0;
        wDelay   = 3;
        bRespVal = 2'b10;
        sendWrite(32'h0000_0044, 32'h0102_0304);
        waitRsp(base, 1);
        checkCount++;
        if (awHs - awB !== 1 || wHs - wB !== 1)
            $display("[TB] FAIL skew_handshakes got=%0d/%0d required=1/1", awHs - awB, wHs - wB);
        else passCount++;
        checkCount++;
        if (capWdata !== 32'h01020304) $display("[TB] FAIL skew_wdata got=%h required=01020304", capWdata);
        else passCount++;
        checkCount++;
        if (rspData.size() !== base + 1 || rspData[base] !== 8'h02 || rspLast[base] !== 1'b1)
            $display("[TB] FAIL slverr_rsp got=%0d bytes first=%h required=1 bytes 02", rspData.size() - base,
                     (rspData.size() > base) ? rspData[base] : 8'hxx);
        else passCount++;
        wDelay   = 0;
        bRespVal = 2'b00;
    endtask

    task automatic test_badop();
        int base = rspData.size();
        logic [7:0] expB[5] = '{8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h5A};
        sendByte(8'h7A);
        waitRsp(base, 1);
        checkCount++;
        if (rspData.size() !== base + 1 || rspData[base] !== 8'hEE || rspLast[base] !== 1'b1)
            $display("[TB] FAIL badop_rsp got=%0d bytes first=%h required=1 bytes ee", rspData.size() - base,
                     (rspData.size() > base) ? rspData[base] : 8'hxx);
        else passCount++;
        base = rspData.size();
        rDataVal = 32'hA5A5_5A5A;
        sendRead(32'h0000_0030);
        waitRsp(base, 5);
        checkCount++;
        if (capAraddr !== 32'h30) $display("[TB] FAIL badop_next_araddr got=%h required=30", capAraddr);
        else passCount++;
        for (int i = 0; i < 5 && base + i < rspData.size(); i++) begin
            checkCount++;
            if (rspData[base+i] !== expB[i])
                $display("[TB] FAIL badop_next_byte%0d got=%h required=%h", i, rspData[base+i], expB[i]);
            else passCount++;
        end
    endtask

    task automatic test_backpressure();
        int base = rspData.size();
        logic [7:0] expB[5] = '{8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        int stableErr = 0;
        bit stallPending = 1'b0;
        logic [7:0] held = 8'h00;
        rDataVal = 32'hCAFE_F00D;
        rRespVal = 2'b01;
        rspReady = 1'b0;
        sendRead(32'h0000_0050);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (stallPending && (mTvalid !== 1'b1 || mTdata !== held)) stableErr++;
            rspReady     = ~rspReady;
            stallPending = mTvalid && !rspReady;
            held         = mTdata;
        end
        rspReady = 1'b1;
        waitRsp(base, 5);
        checkCount++;
        if (stableErr !== 0) $display("[TB] FAIL bp_stable got=%0d unstable stalls required=0", stableErr);
        else passCount++;
        checkCount++;
        if (rspData.size() !== base + 5) $display("[TB] FAIL bp_count got=%0d required=5", rspData.size() - base);
        else passCount++;
        for (int i = 0; i < 5 && base + i < rspData.size(); i++) begin
            checkCount++;
            if (rspData[base+i] !== expB[i] || rspLast[base+i] !== (i == 4))
                $display("[TB] FAIL bp_byte%0d got=%h/%b required=%h/%b", i, rspData[base+i],
                         rspLast[base+i], expB[i], (i == 4));
            else passCount++;
        end
        rRespVal = 2'b00;
    endtask

    task automatic test_reset_mid();
        int base = rspData.size();
        arReadyEn = 1'b0;
        sendRead(32'h0000_0040);
        repeat (3) @(negedge clk);
        checkCount++;
        if (arvalid !== 1'b1) $display("[TB] FAIL arvalid_held got=%b required=1", arvalid);
        else passCount++;
        arstn = 1'b0;
        #1;
        checkCount++;
        if ({arvalid, mTvalid, sTready} !== 3'b000)
            $display("[TB] FAIL mid_reset got=%b required=000", {arvalid, mTvalid, sTready});
        else passCount++;
        @(negedge clk);
        arstn     = 1'b1;
        arReadyEn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkCount++;
        if (rspData.size() !== base) $display("[TB] FAIL no_rsp_after_reset got=%0d required=0", rspData.size() - base);
        else passCount++;
        rDataVal = 32'h0BAD_CAFE;
        sendRead(32'h0000_0060);
        waitRsp(base, 5);
        checkCount++;
        if (rspData.size() !== base + 5 || rspData[base] !== 8'h00 || rspData[base+4] !== 8'hFE)
            $display("[TB] FAIL post_reset_read got=%0d bytes required=5 bytes 00..fe", rspData.size() - base);
        else passCount++;
    endtask

`ifdef AXIL_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int base = rspData.size();
        int arB = arHs;
        sendByte(8'h02);
        sendByte(8'h00);
        repeat (100) @(posedge clk);
        waitRsp(base, 1);
        checkCount++;
        if (rspData.size() !== base + 1 || rspData[base] !== 8'hFD || rspLast[base] !== 1'b1)
            $display("[TB] FAIL timeout_rsp got=%0d bytes first=%h required=1 bytes fd", rspData.size() - base,
                     (rspData.size() > base) ? rspData[base] : 8'hxx);
        else passCount++;
        checkCount++;
        if (sTready !== 1'b1 || arHs !== arB)
            $display("[TB] FAIL timeout_idle got tready=%b ar=%0d required tready=1 ar=0", sTready, arHs - arB);
        else passCount++;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read_latency();
        test_skew_slverr();
        test_badop();
        test_backpressure();
        test_reset_mid();
`ifdef AXIL_CMD_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
